spi_bus_arbiter: RTL and testbench
==================================

Name: spi_bus_arbiter

Overview:
- SPI mode-0 master that shares the single SD-card SPI bus (sd_clk/sd_mosi/sd_miso/sd_cs) between two requesters, e.g. core MMIO port and a boot loader.
- Grants whole transactions: chip select stays low from a requester's first byte to the byte it flags last.
- Round-robin fairness between transactions; byte-level valid/ready in, single-cycle response pulse out.
- Sits between the requesters and the top-level SD pins.

Parameters:
CLK_DIV, 2, system cycles per sd_clk half-period; legal values >= 1, so sd_clk = CLK / (2*CLK_DIV).

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
req_valid  input  2  per requester: byte offered
req_data  input  16  byte for requester i on bits [8i+7:8i]
req_last  input  2  per requester: this byte ends the transaction
req_ready  output  2  per requester: byte accepted this cycle
resp_valid  output  2  per requester: 1-cycle pulse, received byte valid
resp_data  output  8  received MISO byte, shared by both requesters
busy  output  1  transaction in progress (CS low or gap)
grant  output  1  index of current/last granted requester
sd_clk  output  1  SPI clock, idle low
sd_mosi  output  1  SPI data out, MSB first, idle high
sd_miso  input  1  SPI data in
sd_cs  output  1  chip select, active low

Behaviour:
- Reset (async, immediate, also mid-transfer): sd_cs=1, sd_clk=0, sd_mosi=1, req_ready=0, resp_valid=0, busy=0, grant=1 (so requester 0 wins the first tie), FSM=IDLE, counters=0. An aborted byte produces no resp_valid.
- All outputs are registered; none depends combinationally on inputs.
- FSM states: IDLE, SETUP, LOAD, SHIFT, WAIT, HOLD, GAP.
- IDLE:
  - If exactly one req_valid is set, grant goes to that requester.
  - If both are set, grant goes to the requester != current grant.
  - busy=1 and sd_cs=0, then go to SETUP.
- SETUP: hold CS low, clk low, for CLK_DIV cycles, then go to LOAD.
- LOAD / WAIT:
  - req_ready[grant] = req_valid[grant]; the other req_ready bit stays 0.
  - On accept (cycle T): latch data and last, drive sd_mosi = bit7, enter SHIFT.
  - If no valid byte: stay in WAIT with CS low and clk low. There is no timeout; the other requester stays blocked.
- SHIFT:
  - 8 bits; each bit is CLK_DIV cycles with clk=0, then CLK_DIV cycles with clk=1.
  - sd_miso is sampled on the cycle sd_clk goes high.
  - sd_mosi advances to the next bit on the cycle sd_clk goes low.
  - After the 8th high phase, sd_clk returns to 0.
  - resp_valid[grant] pulses at cycle T+16*CLK_DIV+1, with resp_data = received byte (MSB first).
- After the byte:
  - If last: go to HOLD.
  - Else: go to LOAD. If req_valid[grant] is already high, the next byte is accepted in the same cycle as the resp_valid pulse, giving a back-to-back period of 16*CLK_DIV+1 cycles.
- HOLD: CS low, clk low, for CLK_DIV cycles. Then sd_cs=1, sd_mosi=1, go to GAP.
- GAP: CS high for CLK_DIV cycles, then IDLE with busy=0. A new grant is possible only from IDLE.
- Responses have no backpressure; the requester must take the pulse.
- req_data/req_last of a non-granted requester are ignored. Changing req_data while req_valid is set without ready is a protocol error; the RTL latches whatever is presented on the accept cycle.
- Bit and phase counters: 3-bit bit index, phase counter sized ceil(log2(CLK_DIV+1)). Counters wrap only under FSM control.

Test Plan:
- Reset state: hold RST_N=0 -> sd_cs=1, sd_clk=0, sd_mosi=1, busy=0, req_ready=0. Drop RST_N mid-SHIFT -> same values on the next sample, with no clock edge needed.
- Single byte, CLK_DIV=2, requester 0 sends 0xA5 with last=1, sd_miso tied to sd_mosi:
  - Exactly 8 sd_clk pulses, each 2 cycles high; MOSI pattern 1,0,1,0,0,1,0,1.
  - resp_valid[0] at T+33 with resp_data=0xA5; CS high 2 cycles later, busy=0 2 cycles after that.
- Multi-byte: requester 1 sends 0x40,0x00,0x95 (last on 0x95) with valid held, and the slave model returns 0xFF,0x01,0x3C:
  - CS stays low for all 3 bytes; accepts are spaced 33 cycles apart.
  - Responses are 0xFF, 0x01, 0x3C on resp_valid[1].
- Arbitration: both requesters assert continuously with 1-byte transactions after reset -> grants go 0,1,0,1; CS deasserts between transactions; req_ready is never seen on the non-granted requester.
- Stall: requester 0 sends a first byte without last, then drops valid for 100 cycles while requester 1 is valid:
  - CS stays low and clk stays low; requester 1 is not granted.
  - Requester 0 then sends 0x00 with last -> transaction completes, requester 1 is granted next.
- CLK_DIV=1 corner: back-to-back bytes 0x00 and 0xFF -> sd_clk toggles every cycle, resp period 17 cycles, loopback data correct.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// SPI mode-0 master sharing one SD-card bus between two byte-stream requesters.
// Whole transactions are granted round-robin; CS stays low until the byte flagged last.
module spi_bus_arbiter #(
  parameter int CLK_DIV = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  output logic [7:0]  resp_data,
  output logic        busy,
  output logic        grant,
  output logic        sd_clk,
  output logic        sd_mosi,
  input  logic        sd_miso,
  output logic        sd_cs
);

  localparam int PW = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_WAIT, S_HOLD, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [2:0]      bit_q, bit_d;
  logic            sd_clk_q, sd_clk_d;
  logic            sd_cs_q, sd_cs_d;
  logic            sd_mosi_q, sd_mosi_d;
  logic            busy_q, busy_d;
  logic            grant_q, grant_d;
  logic [1:0]      req_ready_q, req_ready_d;
  logic [1:0]      resp_valid_q, resp_valid_d;

  logic [6:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic            last_q, last_d;
  logic [7:0]      resp_data_q, resp_data_d;

  logic [7:0]      sel_byte;
  logic            sel_last;
  logic            accept;
  logic            phase_done;

  assign sel_byte   = grant_q ? req_data[15:8] : req_data[7:0];
  assign sel_last   = grant_q ? req_last[1] : req_last[0];
  assign accept     = req_ready_q[grant_q] & req_valid[grant_q];
  assign phase_done = (phase_q == PH_LAST);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    sd_clk_d     = sd_clk_q;
    sd_cs_d      = sd_cs_q;
    sd_mosi_d    = sd_mosi_q;
    busy_d       = busy_q;
    grant_d      = grant_q;
    req_ready_d  = 2'b00;
    resp_valid_d = 2'b00;
    tx_d         = tx_q;
    rx_d         = rx_q;
    last_d       = last_q;
    resp_data_d  = resp_data_q;

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          // On a tie the requester that did not hold the previous grant wins
          grant_d = (req_valid == 2'b11) ? ~grant_q : req_valid[1];
          busy_d  = 1'b1;
          sd_cs_d = 1'b0;
          phase_d = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (phase_done) begin
          phase_d              = '0;
          state_d              = S_LOAD;
          req_ready_d[grant_q] = req_valid[grant_q];
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LOAD, S_WAIT: begin
        if (accept) begin
          tx_d      = sel_byte[6:0];
          last_d    = sel_last;
          sd_mosi_d = sel_byte[7];
          phase_d   = '0;
          bit_d     = 3'd0;
          state_d   = S_SHIFT;
        end else begin
          state_d              = S_WAIT;
          req_ready_d[grant_q] = req_valid[grant_q];
        end
      end
      S_SHIFT: begin
        if (!phase_done) begin
          phase_d = phase_q + 1'b1;
        end else begin
          phase_d = '0;
          if (!sd_clk_q) begin
            sd_clk_d = 1'b1;
            rx_d     = {rx_q[6:0], sd_miso};
          end else begin
            sd_clk_d = 1'b0;
            if (bit_q == 3'd7) begin
              bit_d                 = 3'd0;
              resp_valid_d[grant_q] = 1'b1;
              resp_data_d           = rx_q;
              if (last_q) begin
                state_d = S_HOLD;
              end else begin
                // Pre-arm ready so a waiting byte is taken alongside the response
                state_d              = S_LOAD;
                req_ready_d[grant_q] = req_valid[grant_q];
              end
            end else begin
              bit_d     = bit_q + 3'd1;
              sd_mosi_d = tx_q[6];
              tx_d      = {tx_q[5:0], 1'b0};
            end
          end
        end
      end
      S_HOLD: begin
        if (phase_done) begin
          phase_d   = '0;
          sd_cs_d   = 1'b1;
          sd_mosi_d = 1'b1;
          state_d   = S_GAP;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_GAP: begin
        if (phase_done) begin
          phase_d = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      bit_q        <= 3'd0;
      sd_clk_q     <= 1'b0;
      sd_cs_q      <= 1'b1;
      sd_mosi_q    <= 1'b1;
      busy_q       <= 1'b0;
      grant_q      <= 1'b1;
      req_ready_q  <= 2'b00;
      resp_valid_q <= 2'b00;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      sd_clk_q     <= sd_clk_d;
      sd_cs_q      <= sd_cs_d;
      sd_mosi_q    <= sd_mosi_d;
      busy_q       <= busy_d;
      grant_q      <= grant_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_ff @(posedge CLK) begin
    tx_q        <= tx_d;
    rx_q        <= rx_d;
    last_q      <= last_d;
    resp_data_q <= resp_data_d;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = busy_q;
  assign grant      = grant_q;
  assign sd_clk     = sd_clk_q;
  assign sd_mosi    = sd_mosi_q;
  assign sd_cs      = sd_cs_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: a CLK_DIV=2 instance with an SD slave
// model or loopback, and a CLK_DIV=1 instance in loopback.
module tb_spi_bus_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [1:0]  req_valid [2];
  logic [15:0] req_data  [2];
  logic [1:0]  req_last  [2];
  logic [1:0]  req_ready [2];
  logic [1:0]  resp_valid[2];
  logic [7:0]  resp_data [2];
  logic        busy      [2];
  logic        grant     [2];
  logic        sd_clk    [2];
  logic        sd_mosi   [2];
  logic        sd_cs     [2];
  logic        miso0, miso1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] expq   [4][$];
  int         pend   [2][$];
  int         acc_cyc[2][$];
  int         acc_req[2][$];
  int         hi_len [2][$];
  logic       mosi_log[2][$];
  int         cs_rise_cnt[2];
  int         cs_rise_at[2];
  int         busy_fall_at[2];
  int         last_resp[2];
  int         hi_cnt[2];
  logic       prev_clk[2], prev_cs[2], prev_busy[2];

  logic       loopback;
  logic [7:0] slave_q[$];
  logic [7:0] s_cur = 8'hFF;
  logic [2:0] s_bit = 3'd7;
  logic       s_prev_cs = 1'b1;
  logic       s_prev_clk = 1'b0;

  spi_bus_arbiter #(.CLK_DIV(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid[0]), .req_data(req_data[0]), .req_last(req_last[0]),
    .req_ready(req_ready[0]), .resp_valid(resp_valid[0]), .resp_data(resp_data[0]),
    .busy(busy[0]), .grant(grant[0]), .sd_clk(sd_clk[0]), .sd_mosi(sd_mosi[0]),
    .sd_miso(miso0), .sd_cs(sd_cs[0])
  );

  spi_bus_arbiter #(.CLK_DIV(1)) dut_d1 (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid[1]), .req_data(req_data[1]), .req_last(req_last[1]),
    .req_ready(req_ready[1]), .resp_valid(resp_valid[1]), .resp_data(resp_data[1]),
    .busy(busy[1]), .grant(grant[1]), .sd_clk(sd_clk[1]), .sd_mosi(sd_mosi[1]),
    .sd_miso(miso1), .sd_cs(sd_cs[1])
  );

  assign miso0 = loopback ? sd_mosi[0] : s_cur[s_bit];
  assign miso1 = sd_mosi[1];

  initial forever #5 CLK = ~CLK;
  initial forever begin @(posedge CLK); cyc++; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic int divf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [7:0] slave_next();
    if (slave_q.size() > 0) return slave_q.pop_front();
    return 8'hFF;
  endfunction

  // SD slave: presents MSB first, advances on each falling sd_clk
  initial forever begin
    @(negedge CLK);
    if (s_prev_cs && !sd_cs[0]) begin
      s_cur = slave_next();
      s_bit = 3'd7;
    end else if (!sd_cs[0] && s_prev_clk && !sd_clk[0]) begin
      if (s_bit == 3'd0) begin
        s_bit = 3'd7;
        s_cur = slave_next();
      end else begin
        s_bit = s_bit - 3'd1;
      end
    end
    s_prev_cs  = sd_cs[0];
    s_prev_clk = sd_clk[0];
  end

  // Monitor: pops the scoreboard on every response pulse and logs bus activity
  initial forever begin
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      if (!RST_N) begin
        prev_clk[i] = 1'b0; prev_cs[i] = 1'b1; prev_busy[i] = 1'b0; hi_cnt[i] = 0;
      end else begin
        for (int r = 0; r < 2; r++) begin
          if (resp_valid[i][r]) begin
            if (expq[2*i+r].size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL unexpected_resp inst%0d req%0d: got %02h, required no pulse", i, r, resp_data[i]);
            end else begin
              chk($sformatf("resp_data inst%0d req%0d", i, r), resp_data[i], expq[2*i+r].pop_front());
            end
            if (pend[i].size() > 0)
              chk($sformatf("resp_latency inst%0d", i), cyc - pend[i].pop_front(), 16*divf(i)+1);
            last_resp[i] = cyc;
          end
        end
        if ((req_valid[i] & req_ready[i]) != 2'b00) begin
          pend[i].push_back(cyc);
          acc_cyc[i].push_back(cyc);
          acc_req[i].push_back(req_ready[i][1] ? 1 : 0);
        end
        if (req_ready[i] != 2'b00)
          chk($sformatf("ready_only_granted inst%0d", i), req_ready[i], grant[i] ? 2'b10 : 2'b01);
        if (sd_clk[i] && !prev_clk[i]) begin
          mosi_log[i].push_back(sd_mosi[i]);
          hi_cnt[i] = 1;
        end else if (sd_clk[i]) begin
          hi_cnt[i]++;
        end else if (prev_clk[i]) begin
          hi_len[i].push_back(hi_cnt[i]);
        end
        if (sd_cs[i] && !prev_cs[i]) begin
          cs_rise_cnt[i]++;
          cs_rise_at[i] = cyc;
        end
        if (!busy[i] && prev_busy[i]) busy_fall_at[i] = cyc;
        prev_clk[i]  = sd_clk[i];
        prev_cs[i]   = sd_cs[i];
        prev_busy[i] = busy[i];
      end
    end
  end

  task automatic send(input int i, input int r, input logic [7:0] d, input logic l,
                      input logic [7:0] e);
    int n = 0;
    expq[2*i+r].push_back(e);
    req_data[i][8*r +: 8] = d;
    req_last[i][r]        = l;
    req_valid[i][r]       = 1'b1;
    do begin
      @(negedge CLK);
      n++;
    end while (!(req_valid[i][r] && req_ready[i][r]) && n < 3000);
    if (n >= 3000) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout inst%0d req%0d: byte %02h never accepted, required accept", i, r, d);
    end
    @(posedge CLK); #1;
    req_valid[i][r] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((busy[i] || expq[2*i].size() != 0 || expq[2*i+1].size() != 0) && n < 3000);
    if (n >= 3000) begin
      n_cmp++; n_err++;
      $display("FAIL idle_timeout inst%0d: busy=%0d, required return to idle", i, busy[i]);
    end
    @(negedge CLK);
  endtask

  task automatic clr(input int i);
    acc_cyc[i].delete(); acc_req[i].delete(); hi_len[i].delete(); mosi_log[i].delete();
    cs_rise_cnt[i] = 0;
  endtask

  function automatic int bad_hi(input int i, input int v);
    int b = 0;
    for (int k = 0; k < hi_len[i].size(); k++) if (hi_len[i][k] != v) b++;
    return b;
  endfunction

  function automatic int req_pattern(input int i);
    int p = 0;
    for (int k = 0; k < acc_req[i].size(); k++) p |= acc_req[i][k] << k;
    return p;
  endfunction

  initial begin
    logic [7:0] m;
    int bad;
    RST_N    = 1'b0;
    loopback = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 2'b00; req_data[i] = 16'h0; req_last[i] = 2'b00;
      cs_rise_cnt[i] = 0; cs_rise_at[i] = 0; busy_fall_at[i] = 0; last_resp[i] = 0;
      hi_cnt[i] = 0; prev_clk[i] = 1'b0; prev_cs[i] = 1'b1; prev_busy[i] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk("rst sd_cs", sd_cs[i], 1'b1);
      chk("rst sd_clk", sd_clk[i], 1'b0);
      chk("rst sd_mosi", sd_mosi[i], 1'b1);
      chk("rst busy", busy[i], 1'b0);
      chk("rst req_ready", req_ready[i], 2'b00);
      chk("rst resp_valid", resp_valid[i], 2'b00);
      chk("rst grant", grant[i], 1'b1);
    end
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // Single byte 0xA5 in loopback
    clr(0);
    send(0, 0, 8'hA5, 1'b1, 8'hA5);
    wait_idle(0);
    chk("single pulses", hi_len[0].size(), 8);
    chk("single hi_len", bad_hi(0, 2), 0);
    m = 8'h00;
    for (int k = 0; k < mosi_log[0].size(); k++) m = {m[6:0], mosi_log[0][k]};
    chk("single mosi pattern", m, 8'hA5);
    chk("single cs_after_resp", cs_rise_at[0] - last_resp[0], 2);
    chk("single busy_after_cs", busy_fall_at[0] - cs_rise_at[0], 2);

    // Multi-byte on requester 1 with slave data
    loopback = 1'b0;
    slave_q.push_back(8'hFF); slave_q.push_back(8'h01); slave_q.push_back(8'h3C);
    clr(0);
    send(0, 1, 8'h40, 1'b0, 8'hFF);
    send(0, 1, 8'h00, 1'b0, 8'h01);
    send(0, 1, 8'h95, 1'b1, 8'h3C);
    wait_idle(0);
    loopback = 1'b1;
    chk("multi cs_rises", cs_rise_cnt[0], 1);
    chk("multi accepts", acc_cyc[0].size(), 3);
    if (acc_cyc[0].size() >= 3) begin
      chk("multi spacing1", acc_cyc[0][1] - acc_cyc[0][0], 33);
      chk("multi spacing2", acc_cyc[0][2] - acc_cyc[0][1], 33);
    end
    chk("multi grant", grant[0], 1'b1);

    // Asynchronous reset in the middle of a shift
    send(0, 0, 8'hC3, 1'b1, 8'hC3);
    repeat (10) @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk("midrst sd_cs", sd_cs[0], 1'b1);
    chk("midrst sd_clk", sd_clk[0], 1'b0);
    chk("midrst sd_mosi", sd_mosi[0], 1'b1);
    chk("midrst busy", busy[0], 1'b0);
    chk("midrst req_ready", req_ready[0], 2'b00);
    chk("midrst grant", grant[0], 1'b1);
    expq[0].delete();
    pend[0].delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);

    // Round-robin with both requesters always valid
    clr(0);
    fork
      begin send(0, 0, 8'h11, 1'b1, 8'h11); send(0, 0, 8'h22, 1'b1, 8'h22); end
      begin send(0, 1, 8'h33, 1'b1, 8'h33); send(0, 1, 8'h44, 1'b1, 8'h44); end
    join
    wait_idle(0);
    chk("arb accepts", acc_req[0].size(), 4);
    chk("arb order", req_pattern(0), 32'b1010);
    chk("arb cs_rises", cs_rise_cnt[0], 4);

    // Stall: granted requester drops valid mid-transaction
    clr(0);
    bad = 0;
    fork
      begin
        send(0, 0, 8'h5A, 1'b0, 8'h5A);
        repeat (40) @(negedge CLK);
        for (int k = 0; k < 60; k++) begin
          @(negedge CLK);
          if (sd_cs[0] !== 1'b0 || sd_clk[0] !== 1'b0 || req_ready[0][1] !== 1'b0 ||
              grant[0] !== 1'b0) bad++;
        end
        chk("stall hold", bad, 0);
        repeat (10) @(negedge CLK);
        send(0, 0, 8'h00, 1'b1, 8'h00);
      end
      begin
        send(0, 1, 8'h77, 1'b1, 8'h77);
      end
    join
    wait_idle(0);
    chk("stall accepts", acc_req[0].size(), 3);
    chk("stall order", req_pattern(0), 32'b100);

    // CLK_DIV=1 back-to-back loopback
    clr(1);
    send(1, 0, 8'h00, 1'b0, 8'h00);
    send(1, 0, 8'hFF, 1'b1, 8'hFF);
    wait_idle(1);
    chk("div1 pulses", hi_len[1].size(), 16);
    chk("div1 hi_len", bad_hi(1, 1), 0);
    chk("div1 accepts", acc_cyc[1].size(), 2);
    if (acc_cyc[1].size() >= 2) chk("div1 spacing", acc_cyc[1][1] - acc_cyc[1][0], 17);

    for (int q = 0; q < 4; q++) chk($sformatf("exp_queue_empty %0d", q), expq[q].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
